engine_job_ctrl: RTL and testbench

ENGINE_JOB_CTRL -- requirements
Module: engine_job_ctrl

---
 rtl/engine_job_pkg.sv | 17 +
 rtl/engine_job_wdog.sv | 34 +++
 rtl/engine_job_ctrl.sv | 121 ++++++++++++
 tb/tb_engine_job_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/engine_job_pkg.sv
// Shared types and constants for the engine job controller and its watchdog.
package engine_job_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } job_state_t;

    localparam int CNT_W_DEF = 16;

    // Bit positions inside err_o
    localparam int ERR_WDOG     = 0;
    localparam int ERR_MISMATCH = 1;

endpackage

// File: rtl/engine_job_wdog.sv
// RUN-state watchdog: counts enabled cycles and pulses o_timeout for one cycle
// when WDOG_CYC cycles have elapsed. WDOG_CYC = 0 disables the timeout.
module engine_job_wdog #(
    parameter int unsigned WDOG_CYC = 65535
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [W-1:0] LIMIT = (WDOG_CYC > 0) ? W'(WDOG_CYC - 1) : '0;

    logic [W-1:0] r_cnt;
    logic         w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);

    // Wrapping at the limit keeps the timeout a single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || !i_enable) begin
            r_cnt <= '0;
        end else if (w_at_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_timeout = (WDOG_CYC != 0) && i_enable && w_at_limit;

endmodule

// File: rtl/engine_job_ctrl.sv
// Job controller for the downstream loop wrapper: accepts a job, starts the
// engine, counts iterations, and reports completion, timeout and count mismatch.
module engine_job_ctrl
    import engine_job_pkg::*;
#(
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned WDOG_CYC = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [CNT_W-1:0] job_max_lk_i,
    output logic             eng_start_o,
    output logic [CNT_W-1:0] eng_max_lk_o,
    input  logic             eng_ready_i,
    input  logic             eng_done_i,
    output logic             busy_o,
    output logic             evt_done_o,
    output logic [CNT_W-1:0] iter_cnt_o,
    output logic [1:0]       err_o
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && !(&v)) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    job_state_t       r_state;
    logic             r_start;
    logic             r_evt_done;
    logic [CNT_W-1:0] r_max_lk;
    logic [CNT_W-1:0] r_iter;
    logic [1:0]       r_err;

    logic             w_clr;
    logic             w_accept;
    logic             w_timeout;
    logic [CNT_W-1:0] w_iter_next;

    assign w_clr       = rst_i || clear_i;
    assign job_ready_o = (r_state == ST_IDLE) && !clear_i;
    assign w_accept    = job_valid_i && job_ready_o;
    // Includes a ready arriving in the same cycle as done for the mismatch check.
    assign w_iter_next = sat_inc(r_iter, eng_ready_i);

    engine_job_wdog #(
        .WDOG_CYC (WDOG_CYC)
    ) u_wdog (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_enable  (r_state == ST_RUN),
        .i_clear   (clear_i),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_evt_done <= 1'b0;
            r_max_lk   <= '0;
            r_iter     <= '0;
            r_err      <= '0;
        end else begin
            r_start    <= 1'b0;
            r_evt_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_max_lk <= job_max_lk_i;
                        r_iter   <= '0;
                        r_err    <= '0;
                        if (job_max_lk_i != '0) begin
                            r_state <= ST_START;
                            r_start <= 1'b1;
                        end else begin
                            r_state    <= ST_DONE;
                            r_evt_done <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_iter <= w_iter_next;
                    // Done takes priority over a coincident watchdog timeout.
                    if (eng_done_i) begin
                        r_state    <= ST_DONE;
                        r_evt_done <= 1'b1;
                        if (w_iter_next != r_max_lk) begin
                            r_err[ERR_MISMATCH] <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state         <= ST_DONE;
                        r_evt_done      <= 1'b1;
                        r_err[ERR_WDOG] <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_start_o  = r_start;
    assign evt_done_o   = r_evt_done;
    assign eng_max_lk_o = r_max_lk;
    assign iter_cnt_o   = r_iter;
    assign err_o        = r_err;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_engine_job_ctrl.sv
// Directed bench for engine_job_ctrl with a 10-cycle watchdog.
module tb_engine_job_ctrl;

    localparam int CNT_W = 16;
    localparam int WDOG  = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             job_valid = 1'b0;
    logic [CNT_W-1:0] job_max_lk = '0;
    logic             eng_ready = 1'b0;
    logic             eng_done = 1'b0;
    logic             job_ready;
    logic             eng_start;
    logic [CNT_W-1:0] eng_max_lk;
    logic             busy;
    logic             evt_done;
    logic [CNT_W-1:0] iter_cnt;
    logic [1:0]       err;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    engine_job_ctrl #(
        .CNT_W    (CNT_W),
        .WDOG_CYC (WDOG)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clear),
        .job_valid_i  (job_valid),
        .job_ready_o  (job_ready),
        .job_max_lk_i (job_max_lk),
        .eng_start_o  (eng_start),
        .eng_max_lk_o (eng_max_lk),
        .eng_ready_i  (eng_ready),
        .eng_done_i   (eng_done),
        .busy_o       (busy),
        .evt_done_o   (evt_done),
        .iter_cnt_o   (iter_cnt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start === 1'b1) start_cnt++;
    end

    // Each step lands 1 time unit after the rising edge: outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (eng_start !== 1'b0 || evt_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got start=%b evt=%b want 0 0", eng_start, evt_done); end
        n_vec++; if (iter_cnt !== 16'd0 || eng_max_lk !== 16'd0) begin n_err++; $display("FAIL reset_counts: got iter=%0d max=%0d want 0 0", iter_cnt, eng_max_lk); end
        n_vec++; if (err !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b want 00", err); end
        rst = 1'b0;
        #1;
        n_vec++; if (job_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_normal();
        job_valid = 1'b1; job_max_lk = 16'd3;
        tick();
        job_valid = 1'b0;
        n_vec++; if (eng_start !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL normal_start: got start=%b busy=%b want 1 1", eng_start, busy); end
        n_vec++; if (eng_max_lk !== 16'd3) begin n_err++; $display("FAIL normal_max: got %0d want 3", eng_max_lk); end
        tick();
        n_vec++; if (eng_start !== 1'b0) begin n_err++; $display("FAIL normal_start_width: got %b want 0", eng_start); end
        eng_ready = 1'b1;
        tick(); tick(); tick();
        eng_ready = 1'b0; eng_done = 1'b1;
        n_vec++; if (iter_cnt !== 16'd3 || evt_done !== 1'b0) begin n_err++; $display("FAIL normal_iter: got iter=%0d evt=%b want 3 0", iter_cnt, evt_done); end
        tick();
        eng_done = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || err !== 2'b00) begin n_err++; $display("FAIL normal_done: got evt=%b err=%b want 1 00", evt_done, err); end
        tick();
        n_vec++; if (evt_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL normal_idle: got evt=%b busy=%b want 0 0", evt_done, busy); end
    endtask

    task automatic test_mismatch();
        job_valid = 1'b1; job_max_lk = 16'd4;
        tick();
        job_valid = 1'b0;
        tick();
        eng_ready = 1'b1;
        tick(); tick();
        eng_ready = 1'b0; eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || err !== 2'b10 || iter_cnt !== 16'd2) begin n_err++; $display("FAIL mismatch_done: got evt=%b err=%b iter=%0d want 1 10 2", evt_done, err, iter_cnt); end
        tick();
        // Ready and done in IDLE must be ignored; error stays sticky.
        eng_ready = 1'b1; eng_done = 1'b1;
        tick(); tick();
        eng_ready = 1'b0; eng_done = 1'b0;
        n_vec++; if (err !== 2'b10 || iter_cnt !== 16'd2 || busy !== 1'b0) begin n_err++; $display("FAIL mismatch_hold: got err=%b iter=%0d busy=%b want 10 2 0", err, iter_cnt, busy); end
    endtask

    task automatic test_zero();
        int s0;
        s0 = start_cnt;
        job_valid = 1'b1; job_max_lk = 16'd0;
        tick();
        job_valid = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || eng_start !== 1'b0 || err !== 2'b00) begin n_err++; $display("FAIL zero_done: got evt=%b start=%b err=%b want 1 0 00", evt_done, eng_start, err); end
        tick();
        tick();
        n_vec++; if (start_cnt - s0 !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_nostart: got starts=%0d busy=%b want 0 0", start_cnt - s0, busy); end
    endtask

    task automatic test_timeout();
        int k;
        int seen;
        job_valid = 1'b1; job_max_lk = 16'd5;
        tick();
        job_valid = 1'b0;
        seen = 0;
        for (k = 1; k <= 20 && seen == 0; k++) begin
            tick();
            if (evt_done === 1'b1) seen = k;
        end
        n_vec++; if (seen !== WDOG + 1) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", seen, WDOG + 1); end
        n_vec++; if (err !== 2'b01) begin n_err++; $display("FAIL timeout_err: got %b want 01", err); end
        tick();
        n_vec++; if (busy !== 1'b0 || err !== 2'b01) begin n_err++; $display("FAIL timeout_idle: got busy=%b err=%b want 0 01", busy, err); end
    endtask

    task automatic test_timeout_done();
        job_valid = 1'b1; job_max_lk = 16'd2;
        tick();
        job_valid = 1'b0;
        tick();
        eng_ready = 1'b1;
        tick(); tick();
        eng_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        n_vec++; if (evt_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tdone_pre: got evt=%b busy=%b want 0 1", evt_done, busy); end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || err !== 2'b00 || iter_cnt !== 16'd2) begin n_err++; $display("FAIL tdone_done: got evt=%b err=%b iter=%0d want 1 00 2", evt_done, err, iter_cnt); end
        tick();
    endtask

    task automatic test_clear();
        int s0;
        job_valid = 1'b1; job_max_lk = 16'd5;
        tick();
        job_valid = 1'b0;
        tick();
        eng_ready = 1'b1;
        tick(); tick();
        eng_ready = 1'b0;
        n_vec++; if (iter_cnt !== 16'd2 || busy !== 1'b1) begin n_err++; $display("FAIL clear_pre: got iter=%0d busy=%b want 2 1", iter_cnt, busy); end
        clear = 1'b1;
        tick();
        job_valid = 1'b1; job_max_lk = 16'd7;
        #1;
        n_vec++; if (busy !== 1'b0 || iter_cnt !== 16'd0 || evt_done !== 1'b0 || eng_max_lk !== 16'd0) begin n_err++; $display("FAIL clear_state: got busy=%b iter=%0d evt=%b max=%0d want 0 0 0 0", busy, iter_cnt, evt_done, eng_max_lk); end
        n_vec++; if (job_ready !== 1'b0) begin n_err++; $display("FAIL clear_blocks_ready: got %b want 0", job_ready); end
        s0 = start_cnt;
        tick();
        job_valid = 1'b0;
        n_vec++; if (busy !== 1'b0 || eng_start !== 1'b0) begin n_err++; $display("FAIL clear_no_accept: got busy=%b start=%b want 0 0", busy, eng_start); end
        clear = 1'b0;
        #1;
        n_vec++; if (job_ready !== 1'b1) begin n_err++; $display("FAIL clear_ready_back: got %b want 1", job_ready); end
        tick();
        n_vec++; if (start_cnt - s0 !== 0 || evt_done !== 1'b0) begin n_err++; $display("FAIL clear_quiet: got starts=%0d evt=%b want 0 0", start_cnt - s0, evt_done); end
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = start_cnt;
        job_valid = 1'b1; job_max_lk = 16'd1;
        tick();
        job_max_lk = 16'd2;
        n_vec++; if (eng_start !== 1'b1 || eng_max_lk !== 16'd1) begin n_err++; $display("FAIL b2b_start1: got start=%b max=%0d want 1 1", eng_start, eng_max_lk); end
        tick();
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0; eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || err !== 2'b00 || job_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done1: got evt=%b err=%b ready=%b want 1 00 0", evt_done, err, job_ready); end
        tick();
        n_vec++; if (busy !== 1'b0 || job_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap: got busy=%b ready=%b want 0 1", busy, job_ready); end
        tick();
        job_valid = 1'b0;
        n_vec++; if (eng_start !== 1'b1 || eng_max_lk !== 16'd2 || iter_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_start2: got start=%b max=%0d iter=%0d want 1 2 0", eng_start, eng_max_lk, iter_cnt); end
        tick();
        eng_ready = 1'b1;
        tick(); tick();
        eng_ready = 1'b0; eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        n_vec++; if (evt_done !== 1'b1 || err !== 2'b00 || iter_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_done2: got evt=%b err=%b iter=%0d want 1 00 2", evt_done, err, iter_cnt); end
        tick();
        n_vec++; if (start_cnt - s0 !== 2) begin n_err++; $display("FAIL b2b_start_count: got %0d want 2", start_cnt - s0); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_mismatch();
        test_zero();
        test_timeout();
        test_timeout_done();
        test_clear();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish by 100000");
        $fatal(1, "bench time limit exceeded");
    end

endmodule
